mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates NUM_PORTS cache line requesters onto one memory port
// Port 0 is the instruction cache and port 1 is the data cache.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_address/read/write/wdata   per-port requests, port i in slice i
//   req_resp, req_rdata            per-port completion pulse, broadcast read line
//   pmem_resp, pmem_rdata          memory completion and read line
//   pmem_address/read/write/wdata  registered memory command
// Macro MEM_ARBITER_FIXED_PRIORITY_EN selects fixed priority (lowest index wins)
// instead of the default round-robin.
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic [LINE_WIDTH-1:0]            req_rdata,
  input  logic                             pmem_resp,
  input  logic [LINE_WIDTH-1:0]            pmem_rdata,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [LINE_WIDTH-1:0]            pmem_wdata
);
  localparam int GW = $clog2(NUM_PORTS);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_next;
  logic [NUM_PORTS-1:0] req;
  logic [GW-1:0] sel, grant, j;
  logic load, done;
  assign req  = req_read | req_write;
  assign load = state == IDLE && |req;
  assign done = state == BUSY && pmem_resp;
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
  // scan downwards so the lowest requesting index is the last to assign
  always_comb begin
    sel = '0;
    j = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = GW'(i);
      if (req[j]) sel = j;
    end
  end
`else
  logic [GW-1:0] last_grant;
  // scan from farthest to nearest after last_grant so the nearest requester wins
  always_comb begin
    sel = '0;
    j = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      j = GW'((int'(last_grant) + k) % NUM_PORTS);
      if (req[j]) sel = j;
    end
  end
  always_ff @(posedge clk)
    last_grant <= rst ? GW'(NUM_PORTS - 1) : load ? sel : last_grant;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_next;
  always_comb state_next = load ? BUSY : done ? IDLE : state;
  always_ff @(posedge clk)
    if (rst) begin
      grant        <= '0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
    end else if (load) begin
      grant        <= sel;
      pmem_address <= req_address[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
      pmem_wdata   <= req_wdata[int'(sel)*LINE_WIDTH +: LINE_WIDTH];
      pmem_write   <= req_write[sel];
      pmem_read    <= ~req_write[sel];
    end else if (done) begin
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
    end
  assign req_resp  = done ? NUM_PORTS'(1) << grant : '0;
  assign req_rdata = done ? pmem_rdata : '0;
endmodule
